// File: rtl/phase_capture_pkg.sv
// Shared definitions for phase_capture: command opcodes, status word layout and
// counter width, plus a saturating increment used by all the free-running counters.
package phase_capture_pkg;

  localparam int CNT_W = 20;
  localparam int CMD_W = 24;

  typedef enum logic [3:0] {
    OP_SELECT      = 4'h1,
    OP_READ_PHASE  = 4'h2,
    OP_READ_PERIOD = 4'h3,
    OP_READ_STATUS = 4'h4,
    OP_CLEAR       = 4'h5
  } opcode_e;

  // Bit positions inside the low nibble of the READ_STATUS reply.
  localparam int ST_LEN_ERR = 0;
  localparam int ST_OVF_ERR = 1;
  localparam int ST_SEL_ERR = 2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser plus history flop for asynchronous bus inputs; every
// instance has the same latency so data lines stay aligned with their clock.
module sync_edge #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  input  logic         i_en,
  output logic [W-1:0] o_level,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] meta_q, sync_q, hist_q;

  // NOTE: non-blocking assignments so each stage samples the previous stage's old value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign o_level = sync_q;
  assign o_rise  = sync_q & ~hist_q & {W{i_en}};

endmodule

// File: rtl/phase_capture.sv
// Receiver for the phase generator's serial driver bus: deserialises and latches
// every line, measures the phase of one selected output against sync, answers commands.
module phase_capture
  import phase_capture_pkg::*;
#(
  parameter int N_CHANNELS = 16,
  parameter int DEPTH      = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [N_CHANNELS-1:0]         i_channel,
  input  logic                          i_data_clk,
  input  logic                          i_latch,
  input  logic                          i_sync,
  output logic [N_CHANNELS*DEPTH-1:0]   o_outputs,
  output logic                          o_frame,
  input  logic                          i_command,
  input  logic [CMD_W-1:0]              i_command_data,
  output logic                          o_reply,
  output logic [CMD_W-1:0]              o_reply_data
);

  localparam int              CH_W    = $clog2(N_CHANNELS);
  localparam int              BIT_W   = $clog2(DEPTH);
  localparam logic [7:0]      N_CH_8  = 8'(N_CHANNELS);
  localparam logic [7:0]      DEPTH_8 = 8'(DEPTH);
  localparam logic [CNT_W-1:0] NO_EDGE = '1;

  // ---------------- input conditioning ----------------
  logic [N_CHANNELS-1:0] ch_lvl, ch_rise_unused;
  logic                  clk_rise, latch_rise, sync_rise;
  logic                  dclk_lvl_unused, latch_lvl_unused, sync_lvl_unused;
  logic [1:0]            arm_q, arm_d;
  logic                  edge_en;

  // Edges stay masked until the synchroniser and history flops hold real levels.
  assign arm_d   = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
  assign edge_en = (arm_q == 2'd3);

  sync_edge #(.W(N_CHANNELS)) u_sync_ch (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_channel), .i_en(edge_en),
    .o_level(ch_lvl), .o_rise(ch_rise_unused)
  );
  sync_edge #(.W(1)) u_sync_dclk (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_data_clk), .i_en(edge_en),
    .o_level(dclk_lvl_unused), .o_rise(clk_rise)
  );
  sync_edge #(.W(1)) u_sync_latch (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_latch), .i_en(edge_en),
    .o_level(latch_lvl_unused), .o_rise(latch_rise)
  );
  sync_edge #(.W(1)) u_sync_sync (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_sync), .i_en(edge_en),
    .o_level(sync_lvl_unused), .o_rise(sync_rise)
  );

  // ---------------- state ----------------
  logic [N_CHANNELS-1:0][DEPTH-1:0] shift_q, shift_d, outputs_q, outputs_d;
  logic                             frame_q, frame_d;
  logic [7:0]                       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]                 cyc_q, cyc_d, period_q, period_d;
  logic [CNT_W-1:0]                 phase_q, phase_d, pending_q, pending_d;
  logic                             len_err_q, len_err_d, ovf_err_q, ovf_err_d;
  logic                             sel_err_q, sel_err_d;
  logic [CH_W-1:0]                  sel_ch_q, sel_ch_d;
  logic [BIT_W-1:0]                 sel_bit_q, sel_bit_d;
  logic                             reply_q, reply_d;
  logic [CMD_W-1:0]                 reply_data_q, reply_data_d;

  logic [7:0] cmd_ch, cmd_bit;
  logic [3:0] status_flags;
  logic       sel_edge;

  assign cmd_ch  = i_command_data[15:8];
  assign cmd_bit = i_command_data[7:0];

  always_comb begin
    status_flags             = '0;
    status_flags[ST_LEN_ERR] = len_err_q;
    status_flags[ST_OVF_ERR] = ovf_err_q;
    status_flags[ST_SEL_ERR] = sel_err_q;
  end

  // NOTE: every signal gets its default first so no path through the block infers a latch.
  always_comb begin
    shift_d      = shift_q;
    outputs_d    = outputs_q;
    frame_d      = 1'b0;
    bit_cnt_d    = bit_cnt_q;
    len_err_d    = len_err_q;
    ovf_err_d    = ovf_err_q;
    sel_err_d    = sel_err_q;
    cyc_d        = sat_inc(cyc_q);
    period_d     = period_q;
    phase_d      = phase_q;
    pending_d    = pending_q;
    sel_ch_d     = sel_ch_q;
    sel_bit_d    = sel_bit_q;
    reply_d      = 1'b0;
    reply_data_d = reply_data_q;
    sel_edge     = 1'b0;

    if (clk_rise) begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        shift_d[c] = {shift_q[c][DEPTH-2:0], ch_lvl[c]};
      end
      if (bit_cnt_q != 8'hFF) bit_cnt_d = bit_cnt_q + 8'd1;
    end

    // The latch sees the post-shift image when both edges land in one cycle.
    if (latch_rise) begin
      outputs_d = shift_d;
      frame_d   = 1'b1;
      if (bit_cnt_d != DEPTH_8) len_err_d = 1'b1;
      bit_cnt_d = '0;
      sel_edge  = !outputs_q[sel_ch_q][sel_bit_q] && shift_d[sel_ch_q][sel_bit_q];
    end

    if (cyc_q == NO_EDGE) ovf_err_d = 1'b1;

    if (sync_rise) begin
      period_d  = sat_inc(cyc_q);
      cyc_d     = '0;
      phase_d   = pending_q;
      pending_d = NO_EDGE;
    end

    // cyc_d is the cycle's position in the (possibly just restarted) period.
    if (sel_edge && pending_d == NO_EDGE) pending_d = cyc_d;

    if (i_command) begin
      case (opcode_e'(i_command_data[23:20]))
        OP_SELECT: begin
          pending_d = NO_EDGE;
          if (cmd_ch < N_CH_8 && cmd_bit < DEPTH_8) begin
            sel_ch_d  = cmd_ch[CH_W-1:0];
            sel_bit_d = cmd_bit[BIT_W-1:0];
          end else begin
            sel_err_d = 1'b1;
          end
        end
        OP_READ_PHASE: begin
          reply_d      = 1'b1;
          reply_data_d = {OP_READ_PHASE, phase_q};
        end
        OP_READ_PERIOD: begin
          reply_d      = 1'b1;
          reply_data_d = {OP_READ_PERIOD, period_q};
        end
        OP_READ_STATUS: begin
          reply_d      = 1'b1;
          reply_data_d = {OP_READ_STATUS, 8'h00, bit_cnt_q, status_flags};
        end
        OP_CLEAR: begin
          len_err_d = 1'b0;
          ovf_err_d = 1'b0;
          sel_err_d = 1'b0;
          phase_d   = NO_EDGE;
          pending_d = NO_EDGE;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the shift and output arrays are plain flops, so they reset with everything
  // else; a partial frame must never survive a reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      arm_q        <= '0;
      shift_q      <= '0;
      outputs_q    <= '0;
      frame_q      <= 1'b0;
      bit_cnt_q    <= '0;
      cyc_q        <= '0;
      period_q     <= '0;
      phase_q      <= NO_EDGE;
      pending_q    <= NO_EDGE;
      len_err_q    <= 1'b0;
      ovf_err_q    <= 1'b0;
      sel_err_q    <= 1'b0;
      sel_ch_q     <= '0;
      sel_bit_q    <= '0;
      reply_q      <= 1'b0;
      reply_data_q <= '0;
    end else begin
      arm_q        <= arm_d;
      shift_q      <= shift_d;
      outputs_q    <= outputs_d;
      frame_q      <= frame_d;
      bit_cnt_q    <= bit_cnt_d;
      cyc_q        <= cyc_d;
      period_q     <= period_d;
      phase_q      <= phase_d;
      pending_q    <= pending_d;
      len_err_q    <= len_err_d;
      ovf_err_q    <= ovf_err_d;
      sel_err_q    <= sel_err_d;
      sel_ch_q     <= sel_ch_d;
      sel_bit_q    <= sel_bit_d;
      reply_q      <= reply_d;
      reply_data_q <= reply_data_d;
    end
  end

  assign o_outputs    = outputs_q;
  assign o_frame      = frame_q;
  assign o_reply      = reply_q;
  assign o_reply_data = reply_data_q;

endmodule

// File: tb/tb_phase_capture.sv
// Directed bench for phase_capture: drives the serial bus and command port, and
// checks replies through a scoreboard of expected words and arrival cycles.
module tb_phase_capture;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic [15:0]  i_channel;
  logic         i_data_clk, i_latch, i_sync;
  logic [127:0] o_outputs;
  logic         o_frame;
  logic         i_command;
  logic [23:0]  i_command_data;
  logic         o_reply;
  logic [23:0]  o_reply_data;

  phase_capture dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_channel(i_channel),
    .i_data_clk(i_data_clk), .i_latch(i_latch), .i_sync(i_sync),
    .o_outputs(o_outputs), .o_frame(o_frame),
    .i_command(i_command), .i_command_data(i_command_data),
    .o_reply(o_reply), .o_reply_data(o_reply_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [23:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_tb = 0;
  int   frames = 0;
  int   replies_seen = 0;

  task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  always @(posedge i_clk) cyc_tb <= cyc_tb + 1;

  // Reply scoreboard and frame counter, sampled on the falling edge.
  always @(negedge i_clk) begin
    exp_t e;
    if (o_frame) frames++;
    if (o_reply) begin
      replies_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_reply", 128'(o_reply), 128'(0));
      end else begin
        e = exp_q.pop_front();
        check("reply_data", 128'(o_reply_data), 128'(e.data));
        check("reply_cycle", 128'(cyc_tb), 128'(e.cyc));
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc_tb) begin
      e = exp_q.pop_front();
      check("reply_missing", 128'(o_reply), 128'(1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc_tb);
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc_tb < t) @(negedge i_clk);
  endtask

  task automatic shift_bit(input logic [15:0] v);
    i_channel = v;
    wait_cyc(4);
    i_data_clk = 1'b1;
    wait_cyc(4);
    i_data_clk = 1'b0;
    wait_cyc(4);
  endtask

  task automatic pulse_latch();
    i_latch = 1'b1;
    wait_cyc(4);
    i_latch = 1'b0;
    wait_cyc(4);
  endtask

  task automatic pulse_sync();
    i_sync = 1'b1;
    wait_cyc(4);
    i_sync = 1'b0;
  endtask

  task automatic cmd(input logic [23:0] word, input bit has_reply, input logic [23:0] expected);
    exp_t e;
    i_command      = 1'b1;
    i_command_data = word;
    if (has_reply) begin
      e.data = expected;
      e.cyc  = cyc_tb + 1;
      exp_q.push_back(e);
    end
    @(negedge i_clk);
    i_command = 1'b0;
  endtask

  initial begin
    logic [7:0]   pattern;
    logic [127:0] exp_out;
    int           f0, r0, s0;

    i_rst_n = 1'b0; i_channel = '0; i_data_clk = 1'b0; i_latch = 1'b0; i_sync = 1'b0;
    i_command = 1'b0; i_command_data = '0;
    wait_cyc(3);

    // Reset state
    check("rst_outputs", o_outputs, '0);
    check("rst_frame", 128'(o_frame), 128'(0));
    check("rst_reply", 128'(o_reply), 128'(0));
    check("rst_reply_data", 128'(o_reply_data), 128'(0));
    i_rst_n = 1'b1;
    wait_cyc(5);
    cmd(24'h200000, 1, 24'h2FFFFF);
    cmd(24'h300000, 1, 24'h300000);
    cmd(24'h400000, 1, 24'h400000);
    wait_cyc(3);

    // Basic frame: 0xA5 MSB first on channel 3
    pattern = 8'hA5;
    for (int j = 0; j < 8; j++) shift_bit(16'(pattern[7-j]) << 3);
    f0 = frames;
    pulse_latch();
    wait_cyc(4);
    check("basic_frame_count", 128'(frames), 128'(f0 + 1));
    exp_out = '0;
    exp_out[31:24] = 8'hA5;
    check("basic_outputs", o_outputs, exp_out);
    cmd(24'h400000, 1, 24'h400000);
    wait_cyc(3);

    // Short frame, then clear
    for (int j = 0; j < 7; j++) shift_bit(16'h0080);
    cmd(24'h400000, 1, 24'h400070);
    wait_cyc(2);
    pulse_latch();
    wait_cyc(4);
    cmd(24'h400000, 1, 24'h400001);
    cmd(24'h500000, 0, 24'h0);
    cmd(24'h400000, 1, 24'h400000);
    wait_cyc(3);

    // Out-of-range SELECT sets sel_err
    cmd(24'h101000, 0, 24'h0);
    cmd(24'h400000, 1, 24'h400004);
    cmd(24'h500000, 0, 24'h0);
    cmd(24'h400000, 1, 24'h400000);
    wait_cyc(3);

    // Phase measurement on channel 5 bit 2, sync every 1200 cycles
    cmd(24'h100502, 0, 24'h0);
    wait_cyc(2);
    s0 = cyc_tb;
    pulse_sync();
    for (int j = 0; j < 8; j++) shift_bit((j == 5) ? 16'h0020 : 16'h0000);
    wait_until(s0 + 300);
    pulse_latch();
    wait_until(s0 + 1200);
    pulse_sync();
    wait_cyc(4);
    cmd(24'h200000, 1, 24'h20012C);
    cmd(24'h300000, 1, 24'h3004B0);
    wait_cyc(3);

    // Full period with no selected edge
    wait_until(s0 + 2400);
    pulse_sync();
    wait_cyc(4);
    cmd(24'h200000, 1, 24'h2FFFFF);
    cmd(24'h300000, 1, 24'h3004B0);
    wait_cyc(3);

    // Simultaneous data_clk and latch: 0xCD on channel 1, last bit shifted with the latch
    pattern = 8'hCD;
    for (int j = 0; j < 7; j++) shift_bit(16'(pattern[7-j]) << 1);
    f0 = frames;
    i_channel = 16'(pattern[0]) << 1;
    i_data_clk = 1'b1;
    i_latch = 1'b1;
    wait_cyc(4);
    i_data_clk = 1'b0;
    i_latch = 1'b0;
    wait_cyc(6);
    check("simul_frame_count", 128'(frames), 128'(f0 + 1));
    exp_out = '0;
    exp_out[15:8] = 8'hCD;
    check("simul_outputs", o_outputs, exp_out);
    cmd(24'h400000, 1, 24'h400000);
    wait_cyc(3);

    // Invalid opcode, then back-to-back reads
    r0 = replies_seen;
    cmd(24'h900000, 0, 24'h0);
    wait_cyc(3);
    check("invalid_opcode_no_reply", 128'(replies_seen), 128'(r0));
    cmd(24'h300000, 1, 24'h3004B0);
    cmd(24'h200000, 1, 24'h2FFFFF);
    wait_cyc(3);

    // Reset mid-frame with every bus input high across release
    for (int j = 0; j < 3; j++) shift_bit(16'h0001);
    f0 = frames;
    i_channel = 16'hFFFF;
    i_data_clk = 1'b1;
    i_latch = 1'b1;
    i_sync = 1'b1;
    wait_cyc(1);
    i_rst_n = 1'b0;
    #1;
    check("midrst_outputs", o_outputs, '0);
    wait_cyc(3);
    i_rst_n = 1'b1;
    wait_cyc(10);
    check("midrst_no_frame", 128'(frames), 128'(f0));
    check("midrst_outputs_after", o_outputs, '0);
    cmd(24'h400000, 1, 24'h400000);
    cmd(24'h200000, 1, 24'h2FFFFF);
    cmd(24'h300000, 1, 24'h300000);
    wait_cyc(3);
    i_channel = '0;
    i_data_clk = 1'b0;
    i_latch = 1'b0;
    i_sync = 1'b0;
    wait_cyc(8);
    check("midrst_final_frames", 128'(frames), 128'(f0));

    wait_cyc(5);
    check("replies_outstanding", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
